dict_value_compressor_prog: RTL and testbench

//  Serial-in dictionary-value compressor with a run-time loadable codebook. Each CHUNK_SIZE-bit

---
 rtl/dict_value_compressor_prog_if.sv | 32 +++
 rtl/dict_value_compressor_prog.sv | 182 ++++++++++++++++++
 tb/tb_dict_value_compressor_prog.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dict_value_compressor_prog_if.sv
// Bus bundle for the dictionary-value compressor.
// It groups the codebook load port, the serial bit input and the index output stream.
interface dict_value_compressor_prog_if #(
  parameter int CHUNK_SIZE = 4,
  parameter int INDEX_BITS = 3
);
  logic                  flush;
  logic                  cb_wr_en;
  logic [INDEX_BITS-1:0] cb_wr_addr;
  logic [CHUNK_SIZE-1:0] cb_wr_data;
  logic                  cb_clear;
  logic                  data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [INDEX_BITS-1:0] out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_done;

  modport master (
    output flush, cb_wr_en, cb_wr_addr, cb_wr_data, cb_clear,
    output data_in, data_valid, out_ready,
    input  data_ready, out_index, out_last, out_valid, frame_done
  );

  modport slave (
    input  flush, cb_wr_en, cb_wr_addr, cb_wr_data, cb_clear,
    input  data_in, data_valid, out_ready,
    output data_ready, out_index, out_last, out_valid, frame_done
  );
endinterface

// File: rtl/dict_value_compressor_prog.sv
// Serial-in dictionary-value compressor with a run-time loadable codebook.
// Each completed chunk is matched to its closest codebook entry, and the index is queued in a framed output FIFO.
module dict_value_compressor_prog #(
  parameter int CHUNK_SIZE    = 4,
  parameter int CODEBOOK_SIZE = 8,
  parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
  parameter int NUM_CHUNKS    = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  dict_value_compressor_prog_if.slave bus
);
  localparam int BC_W  = $clog2(CHUNK_SIZE + 1);
  localparam int CC_W  = $clog2(NUM_CHUNKS + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PC_W  = $clog2(CHUNK_SIZE + 1);

  localparam logic [BC_W-1:0]  BitLast   = BC_W'(CHUNK_SIZE - 1);
  localparam logic [CC_W-1:0]  ChunkLast = CC_W'(NUM_CHUNKS - 1);
  localparam logic [FC_W-1:0]  FifoFull  = FC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PtrLast   = PTR_W'(FIFO_DEPTH - 1);

  logic [CHUNK_SIZE-1:0]    cb_q [CODEBOOK_SIZE];
  logic [CHUNK_SIZE-1:0]    cb_d [CODEBOOK_SIZE];
  logic [CODEBOOK_SIZE-1:0] cbValid_q, cbValid_d;

  logic [CHUNK_SIZE-2:0] shift_q, shift_d;
  logic [BC_W-1:0]       bitCnt_q, bitCnt_d;
  logic [CC_W-1:0]       chunkCnt_q, chunkCnt_d;

  // Each FIFO entry is {last, index}.
  logic [INDEX_BITS:0] fifo_q [FIFO_DEPTH];
  logic [INDEX_BITS:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [FC_W-1:0]     fifoCnt_q, fifoCnt_d;
  logic                frameDone_q, frameDone_d;

  logic                  cbWrHit;
  logic                  dataReady;
  logic                  outValid;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CHUNK_SIZE-1:0] chunk;
  logic [INDEX_BITS:0]   head;
  logic [PC_W-1:0]       chunkPc;
  logic [PC_W-1:0]       candPd, candHd;
  logic [PC_W-1:0]       bestPd, bestHd;
  logic [INDEX_BITS-1:0] bestIdx;
  logic                  found;

  function automatic logic [PC_W-1:0] popCount(input logic [CHUNK_SIZE-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK_SIZE; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [PC_W-1:0] absDiff(input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PtrLast) ? '0 : p + PTR_W'(1);
  endfunction

  assign cbWrHit   = bus.cb_wr_en && (32'(bus.cb_wr_addr) < CODEBOOK_SIZE);
  assign dataReady = (fifoCnt_q != FifoFull);
  assign outValid  = (fifoCnt_q != '0);
  assign accept    = bus.data_valid && dataReady;
  assign push      = accept && (bitCnt_q == BitLast);
  assign pop       = outValid && bus.out_ready;
  assign chunk     = {shift_q, bus.data_in};
  assign head      = fifo_q[rdPtr_q];

  assign bus.data_ready = dataReady;
  assign bus.out_valid  = outValid;
  assign bus.out_index  = outValid ? head[INDEX_BITS-1:0] : '0;
  assign bus.out_last   = outValid && head[INDEX_BITS];
  assign bus.frame_done = frameDone_q;

  // Strict comparisons keep the earliest entry on a full tie, so the lowest index wins.
  always_comb begin
    chunkPc = popCount(chunk);
    bestIdx = '0;
    bestPd  = '0;
    bestHd  = '0;
    found   = 1'b0;
    candPd  = '0;
    candHd  = '0;
    for (int k = 0; k < CODEBOOK_SIZE; k++) begin
      candPd = absDiff(chunkPc, popCount(cb_q[k]));
      candHd = popCount(chunk ^ cb_q[k]);
      if (cbValid_q[k] && (!found || (candPd < bestPd) ||
                           ((candPd == bestPd) && (candHd < bestHd)))) begin
        found   = 1'b1;
        bestPd  = candPd;
        bestHd  = candHd;
        bestIdx = INDEX_BITS'(k);
      end
    end
  end

  always_comb begin
    cb_d      = cb_q;
    cbValid_d = cbValid_q;
    if (bus.cb_clear) begin
      cbValid_d = '0;
    end else if (cbWrHit) begin
      cb_d[bus.cb_wr_addr]      = bus.cb_wr_data;
      cbValid_d[bus.cb_wr_addr] = 1'b1;
    end
  end

  // Flush wins over the data path and the pop; the codebook path above is independent of it.
  always_comb begin
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    chunkCnt_d  = chunkCnt_q;
    fifo_d      = fifo_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    fifoCnt_d   = fifoCnt_q;
    frameDone_d = 1'b0;
    if (bus.flush) begin
      shift_d    = '0;
      bitCnt_d   = '0;
      chunkCnt_d = '0;
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      fifoCnt_d  = '0;
    end else begin
      if (accept) begin
        shift_d  = (CHUNK_SIZE - 1)'({shift_q, bus.data_in});
        bitCnt_d = push ? '0 : bitCnt_q + BC_W'(1);
      end
      if (push) begin
        fifo_d[wrPtr_q] = {(chunkCnt_q == ChunkLast), bestIdx};
        wrPtr_d         = ptrInc(wrPtr_q);
        chunkCnt_d      = (chunkCnt_q == ChunkLast) ? '0 : chunkCnt_q + CC_W'(1);
      end
      if (pop) begin
        rdPtr_d     = ptrInc(rdPtr_q);
        frameDone_d = head[INDEX_BITS];
      end
      unique case ({push, pop})
        2'b10:   fifoCnt_d = fifoCnt_q + FC_W'(1);
        2'b01:   fifoCnt_d = fifoCnt_q - FC_W'(1);
        default: fifoCnt_d = fifoCnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CODEBOOK_SIZE; k++) cb_q[k] <= '0;
      cbValid_q <= '0;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      chunkCnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      fifoCnt_q   <= '0;
      frameDone_q <= 1'b0;
    end else begin
      cb_q        <= cb_d;
      cbValid_q   <= cbValid_d;
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      chunkCnt_q  <= chunkCnt_d;
      fifo_q      <= fifo_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      fifoCnt_q   <= fifoCnt_d;
      frameDone_q <= frameDone_d;
    end
  end
endmodule

// File: tb/tb_dict_value_compressor_prog.sv
// Testbench for dict_value_compressor_prog: table-driven vectors, directed corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_dict_value_compressor_prog;
  localparam int CS  = 4;
  localparam int CBN = 8;
  localparam int IB  = 3;
  localparam int NC  = 4;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dict_value_compressor_prog_if #(.CHUNK_SIZE(CS), .INDEX_BITS(IB)) bus ();

  dict_value_compressor_prog #(
    .CHUNK_SIZE(CS), .CODEBOOK_SIZE(CBN), .INDEX_BITS(IB), .NUM_CHUNKS(NC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: codebook arrays, a queue of expected FIFO entries and a few counters.
  typedef struct { int idx; bit last; } entry_t;
  int     refCb [CBN];
  bit     refValid [CBN];
  entry_t refQ [$];
  int     refShift, refBitCnt, refChunkCnt;
  bit     refFrameDone;
  int     popTotal = 0, lastPopTotal = 0, frameDoneTotal = 0;

  // Minimum over a lexicographic key (popcount distance, Hamming distance, index).
  function automatic int refIndex(input int c);
    int bestKey, key, p;
    bestKey = -1;
    for (int k = 0; k < CBN; k++) begin
      if (refValid[k]) begin
        p = $countones(c) - $countones(refCb[k]);
        if (p < 0) p = -p;
        key = (p * 16 + $countones(c ^ refCb[k])) * CBN + k;
        if (bestKey < 0 || key < bestKey) bestKey = key;
      end
    end
    return (bestKey < 0) ? 0 : bestKey % CBN;
  endfunction

  function automatic void refReset();
    for (int k = 0; k < CBN; k++) begin
      refCb[k] = 0;
      refValid[k] = 1'b0;
    end
    refQ.delete();
    refShift = 0;
    refBitCnt = 0;
    refChunkCnt = 0;
    refFrameDone = 1'b0;
  endfunction

  // Monitor: checks outputs mid-cycle, then advances the model for the coming rising edge.
  always @(negedge clk) begin : monitor
    bit     doPop, doPush;
    entry_t e;
    if (!rst_n) begin
      refReset();
    end else begin
      checkOutput("out_valid", bus.out_valid, (refQ.size() > 0) ? 1 : 0);
      checkOutput("data_ready", bus.data_ready, (refQ.size() < FD) ? 1 : 0);
      checkOutput("frame_done", bus.frame_done, refFrameDone);
      if (refQ.size() > 0) begin
        checkOutput("out_index", bus.out_index, refQ[0].idx);
        checkOutput("out_last", bus.out_last, refQ[0].last);
      end
      if (bus.frame_done) frameDoneTotal++;
      doPush = 1'b0;
      e.idx = 0;
      e.last = 1'b0;
      if (bus.flush) begin
        refQ.delete();
        refShift = 0;
        refBitCnt = 0;
        refChunkCnt = 0;
        refFrameDone = 1'b0;
      end else begin
        doPop = (refQ.size() > 0) && bus.out_ready;
        refFrameDone = doPop ? refQ[0].last : 1'b0;
        if (bus.data_valid && refQ.size() < FD) begin
          refShift = ((refShift << 1) | int'(bus.data_in)) & ((1 << CS) - 1);
          refBitCnt++;
          if (refBitCnt == CS) begin
            e.idx = refIndex(refShift);
            e.last = (refChunkCnt == NC - 1);
            refChunkCnt = (refChunkCnt + 1) % NC;
            refBitCnt = 0;
            doPush = 1'b1;
          end
        end
        if (doPop) begin
          popTotal++;
          if (refQ[0].last) lastPopTotal++;
          void'(refQ.pop_front());
        end
        if (doPush) refQ.push_back(e);
      end
      if (bus.cb_clear) begin
        for (int k = 0; k < CBN; k++) refValid[k] = 1'b0;
      end else if (bus.cb_wr_en) begin
        refCb[bus.cb_wr_addr] = int'(bus.cb_wr_data);
        refValid[bus.cb_wr_addr] = 1'b1;
      end
    end
  end

  task automatic sendBit(input logic b);
    int   waitCycles;
    logic rdy;
    waitCycles = 0;
    bus.data_in = b;
    bus.data_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = bus.data_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end while (!rdy && waitCycles < 200);
    if (!rdy) checkOutput("bit accept timeout", rdy, 1);
  endtask

  task automatic applyStimulus(input logic [CS-1:0] chunk);
    for (int b = CS - 1; b >= 0; b--) sendBit(chunk[b]);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cbWrite(input int addr, input logic [CS-1:0] data);
    bus.cb_wr_en = 1'b1;
    bus.cb_wr_addr = IB'(addr);
    bus.cb_wr_data = data;
    idleCycles(1);
    bus.cb_wr_en = 1'b0;
  endtask

  task automatic cbClear();
    bus.cb_clear = 1'b1;
    idleCycles(1);
    bus.cb_clear = 1'b0;
  endtask

  task automatic flushPulse();
    bus.flush = 1'b1;
    idleCycles(1);
    bus.flush = 1'b0;
  endtask

  logic [CS-1:0] cbInit [CBN];

  task automatic loadCodebook();
    for (int k = 0; k < CBN; k++) cbWrite(k, cbInit[k]);
  endtask

  typedef struct { logic [CS-1:0] chunk; int idx; bit last; } vec_t;
  vec_t vecs [8];

  initial begin
    int p0, l0, f0;
    cbInit = '{4'b0000, 4'b0010, 4'b1001, 4'b1011, 4'b1111, 4'b1000, 4'b1100, 4'b0111};
    vecs[0] = '{4'b0000, 0, 1'b0};
    vecs[1] = '{4'b0011, 2, 1'b0};
    vecs[2] = '{4'b0110, 6, 1'b0};
    vecs[3] = '{4'b1110, 3, 1'b1};
    vecs[4] = '{4'b0101, 2, 1'b0};
    vecs[5] = '{4'b0001, 1, 1'b0};
    // 0100 ties cb1 and cb5 on both distances, so the lower index is chosen.
    vecs[6] = '{4'b0100, 1, 1'b0};
    vecs[7] = '{4'b1111, 4, 1'b1};

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.cb_wr_en = 1'b0;
    bus.cb_wr_addr = '0;
    bus.cb_wr_data = '0;
    bus.cb_clear = 1'b0;
    bus.data_in = 1'b0;
    bus.data_valid = 1'b0;
    bus.out_ready = 1'b0;
    idleCycles(3);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset data_ready", bus.data_ready, 1);
    checkOutput("reset out_index", bus.out_index, 0);
    checkOutput("reset out_last", bus.out_last, 0);
    checkOutput("reset frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    idleCycles(1);
    loadCodebook();

    $display("[TB] table vectors");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].chunk);
      bus.data_valid = 1'b0;
      checkOutput("vec out_valid", bus.out_valid, 1);
      checkOutput("vec out_index", bus.out_index, vecs[i].idx);
      checkOutput("vec out_last", bus.out_last, vecs[i].last);
      idleCycles(1);
      checkOutput("vec frame_done", bus.frame_done, vecs[i].last);
    end
    idleCycles(2);

    $display("[TB] backpressure");
    p0 = popTotal;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(CS'($urandom_range(0, 15)));
    bus.data_valid = 1'b0;
    checkOutput("bp data_ready full", bus.data_ready, 0);
    checkOutput("bp out_valid full", bus.out_valid, 1);
    fork
      applyStimulus(CS'($urandom_range(0, 15)));
      begin
        idleCycles(6);
        checkOutput("bp still stalled", bus.data_ready, 0);
        bus.out_ready = 1'b1;
      end
    join
    bus.data_valid = 1'b0;
    idleCycles(10);
    checkOutput("bp pop count", popTotal - p0, 5);

    $display("[TB] codebook changes");
    cbClear();
    cbWrite(3, 4'b1011);
    applyStimulus(4'b0000);
    bus.data_valid = 1'b0;
    checkOutput("single entry index", bus.out_index, 3);
    idleCycles(2);
    cbClear();
    applyStimulus(4'b0000);
    bus.data_valid = 1'b0;
    checkOutput("empty codebook index", bus.out_index, 0);
    idleCycles(2);
    bus.cb_clear = 1'b1;
    cbWrite(5, 4'b1000);
    bus.cb_clear = 1'b0;
    applyStimulus(4'b1000);
    bus.data_valid = 1'b0;
    checkOutput("clear beats write", bus.out_index, 0);
    idleCycles(2);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    bus.cb_wr_en = 1'b1;
    bus.cb_wr_addr = 3'd6;
    bus.cb_wr_data = 4'b1100;
    sendBit(1'b0);
    bus.cb_wr_en = 1'b0;
    bus.data_valid = 1'b0;
    checkOutput("same-edge write unseen", bus.out_index, 0);
    idleCycles(2);
    applyStimulus(4'b0000);
    bus.data_valid = 1'b0;
    checkOutput("write seen next chunk", bus.out_index, 6);
    idleCycles(2);

    $display("[TB] flush mid-chunk");
    loadCodebook();
    bus.out_ready = 1'b0;
    applyStimulus(4'b0011);
    applyStimulus(4'b0110);
    sendBit(1'b0);
    sendBit(1'b1);
    bus.data_valid = 1'b0;
    bus.out_ready = 1'b1;
    flushPulse();
    checkOutput("flush out_valid", bus.out_valid, 0);
    checkOutput("flush data_ready", bus.data_ready, 1);
    checkOutput("flush frame_done", bus.frame_done, 0);
    for (int j = 0; j < 4; j++) begin
      applyStimulus((j == 0) ? 4'b1000 : CS'($urandom_range(0, 15)));
      bus.data_valid = 1'b0;
      if (j == 0) checkOutput("flush fresh chunk", bus.out_index, 5);
      checkOutput("flush frame last", bus.out_last, (j == 3) ? 1 : 0);
    end
    idleCycles(2);

    $display("[TB] reset mid-chunk");
    sendBit(1'b0);
    sendBit(1'b1);
    bus.data_valid = 1'b0;
    rst_n = 1'b0;
    idleCycles(1);
    checkOutput("mid reset out_valid", bus.out_valid, 0);
    checkOutput("mid reset data_ready", bus.data_ready, 1);
    rst_n = 1'b1;
    loadCodebook();
    for (int j = 0; j < 4; j++) begin
      applyStimulus((j == 0) ? 4'b1000 : CS'($urandom_range(0, 15)));
      bus.data_valid = 1'b0;
      if (j == 0) checkOutput("reset fresh chunk", bus.out_index, 5);
      checkOutput("reset frame last", bus.out_last, (j == 3) ? 1 : 0);
    end
    idleCycles(2);

    $display("[TB] frame wrap");
    l0 = lastPopTotal;
    f0 = frameDoneTotal;
    for (int j = 0; j < 8; j++) applyStimulus(CS'($urandom_range(0, 15)));
    bus.data_valid = 1'b0;
    idleCycles(5);
    checkOutput("wrap last pops", lastPopTotal - l0, 2);
    checkOutput("wrap frame_done pulses", frameDoneTotal - f0, 2);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      bus.data_valid = ($urandom_range(0, 3) != 0);
      bus.data_in    = 1'($urandom_range(0, 1));
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.cb_wr_en   = ($urandom_range(0, 19) == 0);
      bus.cb_wr_addr = IB'($urandom_range(0, CBN - 1));
      bus.cb_wr_data = CS'($urandom_range(0, 15));
      bus.cb_clear   = ($urandom_range(0, 99) == 0);
      bus.flush      = ($urandom_range(0, 79) == 0);
      idleCycles(1);
    end
    bus.data_valid = 1'b0;
    bus.cb_wr_en = 1'b0;
    bus.cb_clear = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    idleCycles(8);
    checkOutput("drained", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
